// File: rtl/tap_3d_pkg.sv
// Shared TAP definitions: state codes, opcodes, IR capture pattern, reset instruction.
// Reset instruction depends on TAP_IDCODE_EN (IDCODE when defined, BYPASS otherwise).
package tap_3d_pkg;

  typedef enum logic [3:0] {
    ST_EX2_DR = 4'h0,
    ST_EX1_DR = 4'h1,
    ST_SH_DR  = 4'h2,
    ST_PA_DR  = 4'h3,
    ST_SEL_IR = 4'h4,
    ST_UPD_DR = 4'h5,
    ST_CAP_DR = 4'h6,
    ST_SEL_DR = 4'h7,
    ST_EX2_IR = 4'h8,
    ST_EX1_IR = 4'h9,
    ST_SH_IR  = 4'hA,
    ST_PA_IR  = 4'hB,
    ST_RTI    = 4'hC,
    ST_UPD_IR = 4'hD,
    ST_CAP_IR = 4'hE,
    ST_TLR    = 4'hF
  } tap_state_e;

  localparam logic [3:0] OP_EXTEST    = 4'b0000;
  localparam logic [3:0] OP_IDCODE    = 4'b0001;
  localparam logic [3:0] OP_TAPCONFIG = 4'b0011;
  localparam logic [3:0] OP_BYPASS    = 4'b1111;

  localparam logic [3:0] IR_CAPTURE   = 4'b0101;

`ifdef TAP_IDCODE_EN
  localparam logic [3:0] IR_RESET     = OP_IDCODE;
`else
  localparam logic [3:0] IR_RESET     = OP_BYPASS;
`endif

endpackage

// File: rtl/tap_fsm.sv
// 16-state TAP controller: TMS sampled on posedge TCK, state register reset to TLR by TRST_N.
// Latency: state follows TMS by one TCK; no backpressure.
module tap_fsm
  import tap_3d_pkg::*;
(
  input  logic       TCK,
  input  logic       TRST_N,
  input  logic       TMS,
  output logic [3:0] tap_state
);

  tap_state_e state_q;
  tap_state_e state_d;

  always_ff @(posedge TCK or negedge TRST_N) begin
    if (!TRST_N) begin
      state_q <= ST_TLR;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = ST_TLR;
    case (state_q)
      ST_TLR:    state_d = TMS ? ST_TLR    : ST_RTI;
      ST_RTI:    state_d = TMS ? ST_SEL_DR : ST_RTI;
      ST_SEL_DR: state_d = TMS ? ST_SEL_IR : ST_CAP_DR;
      ST_CAP_DR: state_d = TMS ? ST_EX1_DR : ST_SH_DR;
      ST_SH_DR:  state_d = TMS ? ST_EX1_DR : ST_SH_DR;
      ST_EX1_DR: state_d = TMS ? ST_UPD_DR : ST_PA_DR;
      ST_PA_DR:  state_d = TMS ? ST_EX2_DR : ST_PA_DR;
      ST_EX2_DR: state_d = TMS ? ST_UPD_DR : ST_SH_DR;
      ST_UPD_DR: state_d = TMS ? ST_SEL_DR : ST_RTI;
      ST_SEL_IR: state_d = TMS ? ST_TLR    : ST_CAP_IR;
      ST_CAP_IR: state_d = TMS ? ST_EX1_IR : ST_SH_IR;
      ST_SH_IR:  state_d = TMS ? ST_EX1_IR : ST_SH_IR;
      ST_EX1_IR: state_d = TMS ? ST_UPD_IR : ST_PA_IR;
      ST_PA_IR:  state_d = TMS ? ST_EX2_IR : ST_PA_IR;
      ST_EX2_IR: state_d = TMS ? ST_UPD_IR : ST_SH_IR;
      ST_UPD_IR: state_d = TMS ? ST_SEL_DR : ST_RTI;
      default:   state_d = ST_TLR;
    endcase
  end

  assign tap_state = state_q;

endmodule

// File: rtl/tap_controller_3d.sv
// Die-level 3D TAP: FSM, 4-bit IR, bypass/IDCODE DRs and negedge-retimed TDO mux.
// TAP_IDCODE_EN adds the IDCODE register and makes IDCODE the reset instruction.
module tap_controller_3d
  import tap_3d_pkg::*;
#(
  parameter logic [31:0] IDCODE_VALUE = 32'h0000_0001
)
(
  input  logic       TCK,
  input  logic       TRST_N,
  input  logic       TMS,
  input  logic       TDI,
  input  logic       config_tdo,
  output logic [3:0] tap_state,
  output logic [3:0] IR,
  output logic       TDO,
  output logic       TDO_EN
);

  if (IDCODE_VALUE[0] != 1'b1) begin : g_idcode_lsb_check
    $error("IDCODE_VALUE bit 0 must be 1");
  end

  logic [3:0] ir_shift;
  logic       bypass_q;
  logic       sel_config;
  logic       sel_idcode;
  logic       sel_bypass;
  logic       shift_ir;
  logic       shift_dr;
  logic       capture_dr;
  logic       tdo_mux;

  tap_fsm u_tap_fsm (
    .TCK       (TCK),
    .TRST_N    (TRST_N),
    .TMS       (TMS),
    .tap_state (tap_state)
  );

  assign shift_ir   = (tap_state == ST_SH_IR);
  assign shift_dr   = (tap_state == ST_SH_DR);
  assign capture_dr = (tap_state == ST_CAP_DR);

  always_ff @(posedge TCK or negedge TRST_N) begin
    if (!TRST_N) begin
      ir_shift <= 4'b0000;
    end else if (tap_state == ST_CAP_IR) begin
      ir_shift <= IR_CAPTURE;
    end else if (shift_ir) begin
      ir_shift <= {TDI, ir_shift[3:1]};
    end
  end

  // TLR continuously re-forces the reset instruction, not just on TRST_N.
  always_ff @(posedge TCK or negedge TRST_N) begin
    if (!TRST_N) begin
      IR <= IR_RESET;
    end else if (tap_state == ST_TLR) begin
      IR <= IR_RESET;
    end else if (tap_state == ST_UPD_IR) begin
      IR <= ir_shift;
    end
  end

  assign sel_config = (IR == OP_TAPCONFIG);
  assign sel_bypass = !sel_config && !sel_idcode;

  always_ff @(posedge TCK or negedge TRST_N) begin
    if (!TRST_N) begin
      bypass_q <= 1'b0;
    end else if (sel_bypass) begin
      if (capture_dr) begin
        bypass_q <= 1'b0;
      end else if (shift_dr) begin
        bypass_q <= TDI;
      end
    end
  end

`ifdef TAP_IDCODE_EN
  logic [31:0] idcode_shift;

  assign sel_idcode = (IR == OP_IDCODE);

  always_ff @(posedge TCK or negedge TRST_N) begin
    if (!TRST_N) begin
      idcode_shift <= 32'h0000_0000;
    end else if (sel_idcode) begin
      if (capture_dr) begin
        idcode_shift <= IDCODE_VALUE;
      end else if (shift_dr) begin
        idcode_shift <= {TDI, idcode_shift[31:1]};
      end
    end
  end

  always_comb begin
    tdo_mux = bypass_q;
    if (shift_ir) begin
      tdo_mux = ir_shift[0];
    end else if (sel_config) begin
      tdo_mux = config_tdo;
    end else if (sel_idcode) begin
      tdo_mux = idcode_shift[0];
    end
  end
`else
  assign sel_idcode = 1'b0;

  always_comb begin
    tdo_mux = bypass_q;
    if (shift_ir) begin
      tdo_mux = ir_shift[0];
    end else if (sel_config) begin
      tdo_mux = config_tdo;
    end
  end
`endif

  // Half-cycle retiming: TDO is launched on the falling edge so the far end samples it on the next rise.
  always_ff @(negedge TCK or negedge TRST_N) begin
    if (!TRST_N) begin
      TDO    <= 1'b0;
      TDO_EN <= 1'b0;
    end else if (shift_ir || shift_dr) begin
      TDO    <= tdo_mux;
      TDO_EN <= 1'b1;
    end else begin
      TDO    <= 1'b0;
      TDO_EN <= 1'b0;
    end
  end

endmodule

// File: tb/tb_tap_controller_3d.sv
// Self-checking bench for tap_controller_3d with a behavioural 8-bit 3DCR stand-in.
// Expected scan streams come from "captured bits followed by TDI bits"; states from a packed next-state table.
module tb_tap_controller_3d;

  logic       TCK = 1'b0;
  logic       TRST_N = 1'b1;
  logic       TMS = 1'b1;
  logic       TDI = 1'b0;
  logic       config_tdo;
  logic [3:0] tap_state;
  logic [3:0] IR;
  logic       TDO;
  logic       TDO_EN;

  localparam logic [31:0] IDV = 32'h1234_5677;
`ifdef TAP_IDCODE_EN
  localparam logic [3:0] RST_IR = 4'b0001;
  localparam bit         HAS_ID = 1'b1;
`else
  localparam logic [3:0] RST_IR = 4'b1111;
  localparam bit         HAS_ID = 1'b0;
`endif

  tap_controller_3d #(.IDCODE_VALUE(IDV)) dut (
    .TCK        (TCK),
    .TRST_N     (TRST_N),
    .TMS        (TMS),
    .TDI        (TDI),
    .config_tdo (config_tdo),
    .tap_state  (tap_state),
    .IR         (IR),
    .TDO        (TDO),
    .TDO_EN     (TDO_EN)
  );

  always #5 TCK = ~TCK;

  // 3DCR stand-in: 8-bit config register, reset value 0x01
  logic [7:0] cfg_reg;
  logic [7:0] cfg_sh;
  always @(posedge TCK or negedge TRST_N) begin
    if (!TRST_N) begin
      cfg_reg <= 8'h01;
      cfg_sh  <= 8'h00;
    end else if (IR == 4'b0011) begin
      case (tap_state)
        4'h6:    cfg_sh  <= cfg_reg;
        4'h2:    cfg_sh  <= {TDI, cfg_sh[7:1]};
        4'h5:    cfg_reg <= cfg_sh;
        default: ;
      endcase
    end
  end
  assign config_tdo = cfg_sh[0];

  int n_checks = 0;
  int n_fail   = 0;

  // nibble k of each word = next state from state code k for TMS=0 / TMS=1
  logic [63:0] nx0 = 64'hCACC_BABA_62CE_3232;
  logic [63:0] nx1 = 64'hF977_89DD_417F_0155;
  logic [3:0]  m_state;
  logic [3:0]  m_ir;
  logic [7:0]  m_cfg;

  task automatic step(input bit tms, input bit tdi, output logic tdo, output logic en);
    int idx;
    TMS = tms;
    TDI = tdi;
    @(posedge TCK);
    idx = 4 * int'(m_state);
    m_state = tms ? nx1[idx +: 4] : nx0[idx +: 4];
    @(negedge TCK);
    #1;
    tdo = TDO;
    en  = TDO_EN;
    n_checks++;
    if (tap_state !== m_state) begin
      n_fail++;
      $display("FAIL state: tap_state=%h expected=%h (tms=%0d)", tap_state, m_state, tms);
    end
  endtask

  // Full scan from RTI back to RTI; exp holds the n TDO bits expected, LSB first.
  task automatic scan(input bit is_ir, input int n, input logic [63:0] din,
                      input logic [63:0] exp, input string name);
    logic [63:0] got;
    logic t, e;
    got = '0;
    step(1'b1, 1'b0, t, e);
    if (is_ir) step(1'b1, 1'b0, t, e);
    step(1'b0, 1'b0, t, e);
    step(1'b0, 1'b0, t, e);
    got[0] = t;
    n_checks++;
    if (e !== 1'b1) begin
      n_fail++;
      $display("FAIL %s tdo_en_entry: got %b expected 1", name, e);
    end
    for (int i = 0; i < n; i++) begin
      step(i == n - 1, din[i], t, e);
      if (i < n - 1) begin
        got[i+1] = t;
        n_checks++;
        if (e !== 1'b1) begin
          n_fail++;
          $display("FAIL %s tdo_en_shift bit %0d: got %b expected 1", name, i + 1, e);
        end
      end else begin
        n_checks++;
        if (e !== 1'b0 || t !== 1'b0) begin
          n_fail++;
          $display("FAIL %s exit_idle: tdo=%b tdo_en=%b expected 0/0", name, t, e);
        end
      end
    end
    step(1'b1, 1'b0, t, e);
    step(1'b0, 1'b0, t, e);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s tdo_stream: got %h expected %h (%0d bits)", name, got, exp, n);
    end
  endtask

  task automatic ir_scan(input logic [3:0] op, input string name);
    scan(1'b1, 4, {60'd0, op}, 64'h5, name);
    m_ir = op;
    n_checks++;
    if (IR !== m_ir) begin
      n_fail++;
      $display("FAIL %s ir_update: IR=%b expected %b", name, IR, m_ir);
    end
  endtask

  task automatic dr_scan(input int n, input logic [63:0] din, input string name);
    logic [127:0] stream;
    logic [63:0]  mask;
    logic [63:0]  cap;
    int           caplen;
    bit           is_cfg;
    is_cfg = (m_ir == 4'b0011);
    if (is_cfg) begin
      cap = {56'd0, m_cfg};
      caplen = 8;
    end else if (HAS_ID && m_ir == 4'b0001) begin
      cap = {32'd0, IDV};
      caplen = 32;
    end else begin
      cap = 64'd0;
      caplen = 1;
    end
    mask   = (n >= 64) ? '1 : ((64'd1 << n) - 64'd1);
    stream = ({64'd0, din & mask} << caplen) | {64'd0, cap};
    scan(1'b0, n, din & mask, stream[63:0] & mask, name);
    if (is_cfg) begin
      m_cfg = stream[n +: 8];
      n_checks++;
      if (cfg_reg !== m_cfg) begin
        n_fail++;
        $display("FAIL %s cfg_update: 3DCR=%h expected %h", name, cfg_reg, m_cfg);
      end
    end
  endtask

  task automatic do_reset();
    TRST_N = 1'b0;
    #2;
    TRST_N = 1'b1;
    m_state = 4'hF;
    m_ir    = RST_IR;
    m_cfg   = 8'h01;
    @(negedge TCK);
    #1;
  endtask

  task automatic test_reset();
    logic t, e;
    #1;
    TRST_N = 1'b0;
    #1;
    n_checks++;
    if (tap_state !== 4'hF) begin
      n_fail++;
      $display("FAIL reset_state: got %h expected F", tap_state);
    end
    n_checks++;
    if (IR !== RST_IR) begin
      n_fail++;
      $display("FAIL reset_ir: got %b expected %b", IR, RST_IR);
    end
    n_checks++;
    if (TDO !== 1'b0 || TDO_EN !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_tdo: tdo=%b tdo_en=%b expected 0/0", TDO, TDO_EN);
    end
    @(negedge TCK);
    #1;
    TRST_N  = 1'b1;
    m_state = 4'hF;
    m_ir    = RST_IR;
    m_cfg   = 8'h01;
    step(1'b1, 1'b0, t, e);
    step(1'b0, 1'b0, t, e);
  endtask

  task automatic test_tlr_from_shdr();
    logic t, e;
    step(1'b1, 1'b0, t, e);
    step(1'b0, 1'b0, t, e);
    step(1'b0, 1'b0, t, e);
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, t, e);
    n_checks++;
    if (tap_state !== 4'hF || IR !== RST_IR) begin
      n_fail++;
      $display("FAIL five_ones_tlr: state=%h IR=%b expected F/%b", tap_state, IR, RST_IR);
    end
    step(1'b0, 1'b0, t, e);
  endtask

  task automatic test_ir_scan();
    ir_scan(4'b0011, "ir_scan_0011");
  endtask

  task automatic test_tapconfig();
    dr_scan(8, 64'hA5, "tapconfig_a5");
    n_checks++;
    if (cfg_reg !== 8'hA5) begin
      n_fail++;
      $display("FAIL tapconfig_hold: 3DCR=%h expected a5", cfg_reg);
    end
    dr_scan(8, 64'h3C, "tapconfig_readback");
  endtask

  task automatic test_bypass();
    ir_scan(4'b1111, "ir_bypass");
    scan(1'b0, 4, 64'b1011, 64'b0110, "bypass_delay");
  endtask

  task automatic test_idcode();
    ir_scan(4'b0001, "ir_idcode");
    dr_scan(32, {$urandom, $urandom}, "idcode_read");
  endtask

  task automatic test_trst_abort();
    logic t, e;
    do_reset();
    step(1'b0, 1'b0, t, e);
    step(1'b1, 1'b0, t, e);
    step(1'b1, 1'b0, t, e);
    step(1'b0, 1'b0, t, e);
    step(1'b0, 1'b0, t, e);
    step(1'b0, 1'b1, t, e);
    step(1'b0, 1'b1, t, e);
    n_checks++;
    if (e !== 1'b1) begin
      n_fail++;
      $display("FAIL abort_pre_en: tdo_en=%b expected 1", e);
    end
    #2;
    TRST_N = 1'b0;
    #1;
    n_checks++;
    if (tap_state !== 4'hF || TDO_EN !== 1'b0 || TDO !== 1'b0) begin
      n_fail++;
      $display("FAIL abort_immediate: state=%h tdo=%b tdo_en=%b expected F/0/0", tap_state, TDO, TDO_EN);
    end
    n_checks++;
    if (IR !== RST_IR) begin
      n_fail++;
      $display("FAIL abort_ir: IR=%b expected %b", IR, RST_IR);
    end
    @(negedge TCK);
    #1;
    TRST_N  = 1'b1;
    m_state = 4'hF;
    m_ir    = RST_IR;
    m_cfg   = 8'h01;
    step(1'b0, 1'b0, t, e);
  endtask

  task automatic test_random_walk();
    logic t, e;
    bit   sh;
    for (int i = 0; i < 120; i++) begin
      step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), t, e);
      sh = (m_state == 4'hA) || (m_state == 4'h2);
      n_checks++;
      if (e !== sh || (!sh && t !== 1'b0)) begin
        n_fail++;
        $display("FAIL walk_tdo_en: state=%h tdo=%b tdo_en=%b expected en=%b", m_state, t, e, sh);
      end
    end
    do_reset();
    step(1'b0, 1'b0, t, e);
  endtask

  task automatic test_random_scans();
    logic [3:0] op;
    int         len;
    for (int k = 0; k < 30; k++) begin
      if ($urandom_range(0, 2) == 0) begin
        case ($urandom_range(0, 4))
          0:       op = 4'b0000;
          1:       op = 4'b0001;
          2:       op = 4'b0011;
          3:       op = 4'b1111;
          default: op = 4'($urandom_range(0, 15));
        endcase
        ir_scan(op, "rand_ir");
      end else begin
        len = (m_ir == 4'b0011) ? $urandom_range(1, 20) : $urandom_range(1, 40);
        dr_scan(len, {$urandom, $urandom}, "rand_dr");
      end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_tlr_from_shdr();
    test_ir_scan();
    test_tapconfig();
    test_bypass();
    test_idcode();
    test_trst_abort();
    test_random_walk();
    test_random_scans();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/tap_controller_3d.md
# tap_controller_3d

IEEE 1149.1/1838-style TAP controller and instruction register for the die-level 3D test port. Decodes TMS into the 16-state TAP FSM and holds the 4-bit instruction register. Broadcasts `tap_state` and `IR` to the downstream data registers: 3DCR, bypass and IDCODE. Selects and retimes the serial return path onto TDO.

## Interface
- `IDCODE_VALUE`, 32'h0000_0001, device identification word; bit 0 must be 1.
- `TCK`  in  1  test clock; all state changes on posedge unless noted.
- `TRST_N`  in  1  reset, asynchronous, active-low.
- `TMS`  in  1  mode select, sampled on posedge TCK.
- `TDI`  in  1  serial data in; feeds the IR shifter and internal DRs.
- `config_tdo`  in  1  serial out of the 3DCR.
- `tap_state`  out  4  current FSM state code.
- `IR`  out  4  active instruction.
- `TDO`  out  1  serial data out, changes on negedge TCK.
- `TDO_EN`  out  1  high while shifting; pad output enable.

## Operation
- State codes:
  - TLR F, RTI C, SEL_DR 7, CAP_DR 6, SH_DR 2, EX1_DR 1, PA_DR 3, EX2_DR 0, UPD_DR 5.
  - SEL_IR 4, CAP_IR E, SH_IR A, EX1_IR 9, PA_IR B, EX2_IR 8, UPD_IR D.
- Transitions follow the standard TAP graph. TMS=1: TLR→TLR, RTI→SEL_DR, SEL_DR→SEL_IR, SEL_IR→TLR. All Capture/Shift/Exit/Pause/Update branches follow the standard graph.
- Five consecutive TMS=1 reach TLR from any state.
- Opcodes:
  - EXTEST 0000, IDCODE 0001, TAPCONFIG 0011, BYPASS 1111.
  - Any undefined opcode behaves as BYPASS.
- IR shifter (4 bits):
  - CAP_IR loads 4'b0101.
  - SH_IR shifts `{TDI, ir_shift[3:1]}`.
  - UPD_IR copies ir_shift into `IR`.
- In TLR, `IR` is forced to its reset value at every posedge. Reset value is IDCODE when IDCODE_EN is defined, otherwise BYPASS.
- Bypass register (1 bit): CAP_DR loads 0; SH_DR loads TDI. Active for BYPASS, EXTEST and undefined opcodes.
- IDCODE register (32 bits): CAP_DR loads IDCODE_VALUE; SH_DR shifts right with TDI into bit 31. Active only when IR=IDCODE.
- A DR register acts only while its instruction is in `IR`. The 3DCR performs its own capture/shift/update from `tap_state`/`IR`; this block only reads `config_tdo`.
- Serial return mux, evaluated while in SH_IR or SH_DR:
  - SH_IR: ir_shift[0].
  - SH_DR with IR=TAPCONFIG: config_tdo.
  - SH_DR with IR=IDCODE: idcode_shift[0].
  - Otherwise: bypass bit.
- Retiming: on negedge TCK, TDO takes the mux output and TDO_EN=1 when state is SH_IR or SH_DR. Otherwise TDO holds 0 and TDO_EN=0.

## Timing
- Reset (TRST_N=0, asynchronous):
  - tap_state=F; IR per reset value.
  - ir_shift=0, bypass=0, idcode_shift=0.
  - TDO=0, TDO_EN=0.
- TRST_N asserted mid-shift aborts immediately. `IR` is not updated from the partial shift. First posedge after deassertion samples TMS from TLR.
- tap_state changes one posedge after the TMS sample. An action tied to state S happens on the posedge taken while tap_state==S.
- `IR` changes on the posedge leaving UPD_IR. The next DR capture already uses the new IR.
- TDO lags the shifted register by half a TCK. The first TDO bit of a scan is valid from the negedge after entry into SH_*. The last bit is valid through the negedge after the last SH_* cycle.
- Pause states hold all shifters unchanged.
- Exit states hold the shifters and do not drive TDO; TDO_EN=0.

## Configuration
- `TAP_IDCODE_EN` defined:
  - IDCODE register present.
  - IDCODE is the reset instruction.
  - Opcode 0001 selects the IDCODE register.
- `TAP_IDCODE_EN` undefined:
  - No IDCODE register; `IDCODE_VALUE` is unused.
  - Reset instruction is BYPASS.
  - Opcode 0001 decodes as BYPASS.

## Structure
- Package `tap_3d_pkg` holds:
  - the 16 state-code constants;
  - the opcode constants (EXTEST, IDCODE, TAPCONFIG, BYPASS);
  - the IR capture pattern 4'b0101.
- The 3DCR imports the same package.
- One sub-module, `tap_fsm`: TMS→next-state logic plus state register, outputs `tap_state`.
- IR, DR registers and the TDO mux live in the top module.

## Test plan
- Reset, then TMS=1 for 5 TCK from SH_DR → tap_state=F; IR=0001 with `TAP_IDCODE_EN`, 1111 without.
- Reach SH_IR, shift 0011 LSB-first → TDO emits 1,0,1,0 (the capture pattern); IR=0011 after UPD_IR.
- IR=TAPCONFIG, DR scan of 8 bits of 0xA5 → TDO returns the prior config value (0x01 after reset); 3DCR holds 0xA5 after UPD_DR.
- IR=BYPASS, shift pattern 1,1,0,1 → TDO gives 0 (captured) then 1,1,0: one-bit delay.
- With `TAP_IDCODE_EN` and IDCODE_VALUE=32'h1234_5677, DR scan of 32 bits → TDO LSB-first equals 32'h1234_5677.
- Pull TRST_N low in SH_IR after 2 of 4 bits → tap_state=F, TDO_EN=0 at once, IR unchanged from reset value.
